mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction and data caches of CPUS cores.
- Sits between each core's icache/dcache miss interfaces and the RAM model, one level above the per-core datapaths.
- Arbitrates between cores round-robin; dcache has priority over icache within a core.
- Holds one outstanding RAM transaction at a time and returns the wait/load handshake to the granted requester only.

Parameters:
- CPUS, 2, number of cores sharing RAM; the round-robin pointer is $clog2(CPUS) bits wide.
- ERRW, 8, width of the saturating RAM-error counter.

Ports:
- CLK  in  1  system clock, rising-edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  [CPUS]  icache read request per core.
- iaddr  in  [CPUS] x word_t  icache address per core.
- iwait  out  [CPUS]  icache wait; low exactly on the completing cycle.
- iload  out  [CPUS] x word_t  icache read data; ramload broadcast to all cores.
- dREN  in  [CPUS]  dcache read request per core.
- dWEN  in  [CPUS]  dcache write request per core.
- daddr  in  [CPUS] x word_t  dcache address per core.
- dstore  in  [CPUS] x word_t  dcache write data per core.
- dwait  out  [CPUS]  dcache wait; low exactly on the completing cycle.
- dload  out  [CPUS] x word_t  dcache read data; ramload broadcast to all cores.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  word_t  RAM address.
- ramstore  out  word_t  RAM write data.
- ramload  in  word_t  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- err_count  out  ERRW  saturating count of ERROR responses.

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, rr_ptr=0, grant registers cleared, err_count=0.
  - All iwait/dwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0.
- Requests: a core requests if dREN|dWEN (dcache) or iREN (icache).
  - Within a core, dcache beats icache.
  - dREN and dWEN both high is treated as a write.
- IDLE:
  - ram enables are 0.
  - If any request is present, the winner is the first requesting core scanning upward from rr_ptr, wrapping.
  - Register gnt_cpu and gnt_src (ISRC/DSRC); next state is BUSY.
  - With no request, stay in IDLE.
- BUSY: ramREN/ramWEN/ramaddr/ramstore are driven combinationally from the granted requester's live inputs.
  - ramstate=ACCESS: the granted wait goes low this cycle, and load equals ramload the same cycle. Next state is IDLE; rr_ptr becomes gnt_cpu+1 modulo CPUS.
  - ramstate=ERROR: next state is IDLE with no completion (wait stays high, so the requester retries naturally). err_count increments and saturates at all-ones. rr_ptr is unchanged.
  - Granted requester drops its request (REN and WEN both low) before ACCESS: abort to IDLE, rr_ptr unchanged, no wait pulse.
  - FREE/BUSY: remain in BUSY.
- Latency:
  - Grant occurs 1 cycle after the request is seen in IDLE.
  - Completion occurs on the first ACCESS cycle in BUSY.
  - Back-to-back transactions have 1 IDLE bubble between them (minimum 2 cycles per transaction with zero-latency RAM).
- Fairness:
  - A core completing a transaction loses priority to the other core on the next arbitration.
  - A core issuing continuous icache+dcache requests alternates with the other core; it cannot starve it.
- Non-granted requesters hold wait=1 for the entire transaction.
- Asserting nRST mid-BUSY:
  - ram enables drop immediately (async); the transaction is discarded.
  - Requesters must re-present their requests after reset.

Decomposition:
- Shared package additions (mem_arbiter_pkg):
  - arb_state_t {IDLE, BUSY}.
  - req_src_t {ISRC, DSRC}.
- Reuse word_t and ramstate_t from cpu_types_pkg.
- One natural sub-module, rr_picker: purely combinational.
  - Inputs: request vector[CPUS] and rr_ptr.
  - Outputs: winner index and valid.
  - The top-level FSM, muxing and counters stay in mem_arbiter.

Test Plan:
- Single icache read, core0: iREN[0]=1, iaddr=0x100, ramstate ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 from cycle 1. iwait[0]=0 and iload[0]=0xDEADBEEF on cycle 3 only. rr_ptr=1.
- Intra-core priority: core0 iREN and dWEN (daddr=0x200, dstore=0x5) simultaneously -> ramWEN=1, ramaddr=0x200, ramstore=0x5 first. After ACCESS, the icache is served only after core1's turn or when core1 is idle.
- Round-robin: both cores hold dREN continuously, zero-latency ACCESS -> grants alternate core0, core1, core0, core1. Each dwait low pulse is 1 cycle, spaced 2 cycles apart.
- ERROR handling: core1 dREN with ramstate=ERROR for 1 cycle, then ACCESS on retry -> err_count=1, no dwait pulse on the error, completion on the second grant. 256 consecutive errors -> err_count holds at 0xFF.
- Abort: grant to core0 icache, iREN[0] dropped before ACCESS -> return to IDLE, ram enables 0, no iwait pulse, rr_ptr still 0.
- Reset mid-BUSY: nRST low while ramREN=1 -> ramREN=0 immediately, all waits=1, err_count=0. After release, the first grant goes to core0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM handshake state.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/mem_arbiter_pkg.sv
// Arbiter-local enums plus re-exported CPU types; cpu_types_pkg is not wildcard-imported
// anywhere because its BUSY enumerator would collide with the arbiter's BUSY state.
package mem_arbiter_pkg;
   typedef cpu_types_pkg::word_t     word_t;
   typedef cpu_types_pkg::ramstate_t ramstate_t;

   typedef enum logic {IDLE, BUSY} arb_state_t;
   typedef enum logic {ISRC, DSRC} req_src_t;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-miss and RAM-port bundle; slave = the arbiter, master = caches + RAM model.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
   parameter int CPUS = 2
) ();
   logic [CPUS-1:0] iREN;
   word_t           iaddr [CPUS];
   logic [CPUS-1:0] iwait;
   word_t           iload [CPUS];
   logic [CPUS-1:0] dREN;
   logic [CPUS-1:0] dWEN;
   word_t           daddr  [CPUS];
   word_t           dstore [CPUS];
   logic [CPUS-1:0] dwait;
   word_t           dload  [CPUS];
   logic            ramREN;
   logic            ramWEN;
   word_t           ramaddr;
   word_t           ramstore;
   word_t           ramload;
   ramstate_t       ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin winner select: first set request at or above rr_ptr, wrapping.
// Purely combinational, no backpressure of its own.
module rr_picker import mem_arbiter_pkg::*; #(
   parameter  int CPUS = 2,
   localparam int PW   = ptr_width(CPUS)
) (
   input  logic [CPUS-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic [PW-1:0]   win,
   output logic            vld
);
   always_comb begin
      logic [PW-1:0] idx;
      win = '0;
      vld = 1'b0;
      idx = '0;
      for (int k = 0; k < CPUS; k++) begin
         idx = PW'((int'(rr_ptr) + k) % CPUS);
         if (!vld && req[idx]) begin
            vld = 1'b1;
            win = idx;
         end
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among CPUS cores' i/d caches; grant 1 cycle after request, done on first ACCESS.
// Only the granted requester sees wait drop; everyone else holds wait=1 until served.
module mem_arbiter import mem_arbiter_pkg::*; #(
   parameter int CPUS = 2,
   parameter int ERRW = 8
) (
   input  logic            CLK,
   input  logic            nRST,
   mem_arbiter_if.slave    bus,
   output logic [ERRW-1:0] err_count
);
   localparam int PW = ptr_width(CPUS);

   arb_state_t      state, next_state;
   req_src_t        gnt_src, next_gnt_src;
   logic [PW-1:0]   rr_ptr, next_ptr, gnt_cpu, next_gnt_cpu, pick;
   logic            pick_vld, err_inc, done;
   logic            ren, wen;
   word_t           addr, store;
   logic [CPUS-1:0] dreq, req;

   assign dreq = bus.dREN | bus.dWEN;
   assign req  = dreq | bus.iREN;

   rr_picker #(.CPUS(CPUS)) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .win    (pick),
      .vld    (pick_vld)
   );

   always_comb begin
      next_state   = state;
      next_ptr     = rr_ptr;
      next_gnt_cpu = gnt_cpu;
      next_gnt_src = gnt_src;
      err_inc      = 1'b0;
      done         = 1'b0;
      ren          = 1'b0;
      wen          = 1'b0;
      addr         = '0;
      store        = '0;
      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               next_gnt_cpu = pick;
               next_gnt_src = dreq[pick] ? DSRC : ISRC;
               next_state   = BUSY;
            end
         end
         BUSY: begin
            // Enables track the requester's live inputs; REN+WEN together is a write.
            if (gnt_src == DSRC) begin
               wen   = bus.dWEN[gnt_cpu];
               ren   = bus.dREN[gnt_cpu] & ~bus.dWEN[gnt_cpu];
               addr  = bus.daddr[gnt_cpu];
               store = bus.dstore[gnt_cpu];
            end else begin
               ren  = bus.iREN[gnt_cpu];
               addr = bus.iaddr[gnt_cpu];
            end
            if (!(ren || wen)) begin
               next_state = IDLE;
            end else if (bus.ramstate == cpu_types_pkg::ACCESS) begin
               done       = 1'b1;
               next_state = IDLE;
               next_ptr   = (gnt_cpu == PW'(CPUS - 1)) ? '0 : gnt_cpu + 1'b1;
            end else if (bus.ramstate == cpu_types_pkg::ERROR) begin
               err_inc    = 1'b1;
               next_state = IDLE;
            end
         end
      endcase
   end

   assign bus.ramREN   = ren;
   assign bus.ramWEN   = wen;
   assign bus.ramaddr  = addr;
   assign bus.ramstore = store;

   always_comb begin
      bus.iwait = '1;
      bus.dwait = '1;
      if (done) begin
         if (gnt_src == DSRC) bus.dwait[gnt_cpu] = 1'b0;
         else                 bus.iwait[gnt_cpu] = 1'b0;
      end
      for (int c = 0; c < CPUS; c++) begin
         bus.iload[c] = bus.ramload;
         bus.dload[c] = bus.ramload;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt_cpu   <= '0;
         gnt_src   <= ISRC;
         err_count <= '0;
      end else begin
         state   <= next_state;
         rr_ptr  <= next_ptr;
         gnt_cpu <= next_gnt_cpu;
         gnt_src <= next_gnt_src;
         if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int CPUS    = 2;
   localparam int ERRW    = 8;
   localparam int ERR_MAX = (1 << ERRW) - 1;

   logic            CLK = 1'b0;
   logic            nRST;
   logic [ERRW-1:0] err_count;
   int              checks   = 0;
   int              failures = 0;

   // Model: current owner (-1 = none), its source (1 = dcache), whose turn it is, error total.
   int m_owner, m_src, m_turn, m_err;

   mem_arbiter_if #(.CPUS(CPUS)) bus ();

   mem_arbiter #(.CPUS(CPUS), .ERRW(ERRW)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .bus       (bus),
      .err_count (err_count)
   );

   always #5 CLK = ~CLK;

`define CHK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         failures++; \
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); \
      end \
   end

   task automatic clear_req();
      bus.iREN     = '0;
      bus.dREN     = '0;
      bus.dWEN     = '0;
      bus.ramstate = cpu_types_pkg::FREE;
      bus.ramload  = '0;
      for (int c = 0; c < CPUS; c++) begin
         bus.iaddr[c]  = '0;
         bus.daddr[c]  = '0;
         bus.dstore[c] = '0;
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset(input string tag);
      logic [ERRW-1:0] zero_err;
      zero_err = '0;
      nRST = 1'b0;
      #1;
      `CHK({tag, ".ren"},   bus.ramREN,   1'b0)
      `CHK({tag, ".wen"},   bus.ramWEN,   1'b0)
      `CHK({tag, ".iwait"}, bus.iwait,    2'b11)
      `CHK({tag, ".dwait"}, bus.dwait,    2'b11)
      `CHK({tag, ".addr"},  bus.ramaddr,  32'h0)
      `CHK({tag, ".store"}, bus.ramstore, 32'h0)
      `CHK({tag, ".err"},   err_count,    zero_err)
      m_owner = -1;
      m_turn  = 0;
      m_err   = 0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   // Called at cycle start; checks at the falling edge, then advances the model by one cycle.
   task automatic sample(input string tag);
      logic            en_r, en_w, fin;
      word_t           ea, es;
      logic [CPUS-1:0] eiw, edw;
      logic [ERRW-1:0] e_err;
      int              c;
      #4;
      en_r = 1'b0; en_w = 1'b0; fin = 1'b0;
      ea = '0; es = '0; eiw = '1; edw = '1;
      e_err = m_err[ERRW-1:0];
      if (m_owner >= 0) begin
         if (m_src == 1) begin
            en_w = bus.dWEN[m_owner];
            en_r = bus.dREN[m_owner] && !bus.dWEN[m_owner];
            ea   = bus.daddr[m_owner];
            es   = bus.dstore[m_owner];
         end else begin
            en_r = bus.iREN[m_owner];
            ea   = bus.iaddr[m_owner];
         end
         fin = (en_r || en_w) && (bus.ramstate == cpu_types_pkg::ACCESS);
         if (fin && m_src == 1) edw[m_owner] = 1'b0;
         if (fin && m_src == 0) eiw[m_owner] = 1'b0;
      end
      `CHK({tag, ".ren"},   bus.ramREN, en_r)
      `CHK({tag, ".wen"},   bus.ramWEN, en_w)
      `CHK({tag, ".iwait"}, bus.iwait,  eiw)
      `CHK({tag, ".dwait"}, bus.dwait,  edw)
      `CHK({tag, ".err"},   err_count,  e_err)
      if (en_r || en_w) `CHK({tag, ".addr"}, bus.ramaddr, ea)
      if (en_w) `CHK({tag, ".store"}, bus.ramstore, es)
      if (fin && m_src == 1) `CHK({tag, ".dload"}, bus.dload[m_owner], bus.ramload)
      if (fin && m_src == 0) `CHK({tag, ".iload"}, bus.iload[m_owner], bus.ramload)

      if (m_owner < 0) begin
         for (int k = 0; k < CPUS; k++) begin
            c = (m_turn + k) % CPUS;
            if (m_owner < 0 && (bus.iREN[c] || bus.dREN[c] || bus.dWEN[c])) begin
               m_owner = c;
               m_src   = (bus.dREN[c] || bus.dWEN[c]) ? 1 : 0;
            end
         end
      end else if (!(en_r || en_w)) begin
         m_owner = -1;
      end else if (fin) begin
         m_turn  = (m_owner + 1) % CPUS;
         m_owner = -1;
      end else if (bus.ramstate == cpu_types_pkg::ERROR) begin
         if (m_err < ERR_MAX) m_err++;
         m_owner = -1;
      end
   endtask

   initial begin
      logic [ERRW-1:0] sat;
      int r;
      sat = '1;
      clear_req();
      do_reset("rst0");

      // Single icache read with two wait cycles.
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100; bus.ramload = 32'hDEADBEEF;
      sample("s1c0"); `CHK("s1c0.idle_ren", bus.ramREN, 1'b0) next_cycle();
      sample("s1c1"); `CHK("s1c1.ren", bus.ramREN, 1'b1) `CHK("s1c1.addr", bus.ramaddr, 32'h100) next_cycle();
      sample("s1c2"); `CHK("s1c2.iwait", bus.iwait[0], 1'b1) next_cycle();
      bus.ramstate = cpu_types_pkg::ACCESS;
      sample("s1c3"); `CHK("s1c3.iwait", bus.iwait[0], 1'b0) `CHK("s1c3.iload", bus.iload[0], 32'hDEADBEEF) next_cycle();
      bus.iREN[0] = 1'b0; bus.ramstate = cpu_types_pkg::FREE;
      sample("s1c4"); `CHK("s1c4.iwait", bus.iwait[0], 1'b1) next_cycle();

      // Pointer moved past core0: core1 wins a tie.
      bus.iREN = 2'b11; bus.iaddr[1] = 32'h300;
      sample("s1b0"); next_cycle();
      bus.ramstate = cpu_types_pkg::ACCESS;
      sample("s1b1"); `CHK("s1b1.addr", bus.ramaddr, 32'h300) `CHK("s1b1.iwait", bus.iwait, 2'b01) next_cycle();
      clear_req(); sample("s1b2"); next_cycle();

      // Intra-core priority: dcache write before icache read.
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h104;
      bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'h5;
      bus.ramstate = cpu_types_pkg::ACCESS;
      sample("s2c0"); next_cycle();
      sample("s2c1"); `CHK("s2c1.wen", bus.ramWEN, 1'b1) `CHK("s2c1.addr", bus.ramaddr, 32'h200)
      `CHK("s2c1.store", bus.ramstore, 32'h5) `CHK("s2c1.dwait", bus.dwait[0], 1'b0) next_cycle();
      bus.dWEN[0] = 1'b0;
      sample("s2c2"); next_cycle();
      sample("s2c3"); `CHK("s2c3.ren", bus.ramREN, 1'b1) `CHK("s2c3.addr", bus.ramaddr, 32'h104)
      `CHK("s2c3.iwait", bus.iwait[0], 1'b0) next_cycle();
      clear_req(); sample("s2c4"); next_cycle();

      // Round-robin with continuous dREN and zero-latency RAM.
      do_reset("s3rst");
      bus.dREN = 2'b11; bus.daddr[0] = 32'h400; bus.daddr[1] = 32'h500;
      bus.ramstate = cpu_types_pkg::ACCESS;
      for (int k = 0; k < 8; k++) begin
         sample("s3");
         if (k % 2 == 1) begin
            `CHK("s3.addr", bus.ramaddr, (((k / 2) % 2) == 0) ? 32'h400 : 32'h500)
            `CHK("s3.dwait", bus.dwait, (((k / 2) % 2) == 0) ? 2'b10 : 2'b01)
         end else begin
            `CHK("s3.bubble", bus.dwait, 2'b11)
         end
         next_cycle();
      end
      clear_req(); sample("s3end"); next_cycle();

      // ERROR then retry.
      bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h600;
      sample("s4c0"); next_cycle();
      bus.ramstate = cpu_types_pkg::ERROR;
      sample("s4c1"); `CHK("s4c1.dwait", bus.dwait[1], 1'b1) next_cycle();
      bus.ramstate = cpu_types_pkg::ACCESS;
      sample("s4c2"); `CHK("s4c2.err", err_count, 8'd1) next_cycle();
      sample("s4c3"); `CHK("s4c3.dwait", bus.dwait[1], 1'b0) `CHK("s4c3.addr", bus.ramaddr, 32'h600) next_cycle();
      clear_req(); sample("s4c4"); next_cycle();

      // Error counter saturation.
      bus.dREN[0] = 1'b1; bus.ramstate = cpu_types_pkg::ERROR;
      repeat (2 * 260) begin sample("sat"); next_cycle(); end
      sample("satend"); `CHK("sat.err", err_count, sat) next_cycle();
      clear_req(); sample("satclr"); next_cycle();

      // Abort: request dropped mid-grant leaves the pointer on core0.
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h700;
      sample("s5c0"); next_cycle();
      sample("s5c1"); `CHK("s5c1.ren", bus.ramREN, 1'b1) next_cycle();
      bus.iREN[0] = 1'b0;
      sample("s5c2"); `CHK("s5c2.ren", bus.ramREN, 1'b0) `CHK("s5c2.iwait", bus.iwait[0], 1'b1) next_cycle();
      bus.iREN = 2'b11; bus.iaddr[1] = 32'h704;
      sample("s5c3"); next_cycle();
      bus.ramstate = cpu_types_pkg::ACCESS;
      sample("s5c4"); `CHK("s5c4.addr", bus.ramaddr, 32'h700) next_cycle();
      clear_req(); sample("s5c5"); next_cycle();

      // Reset mid-BUSY, then first grant goes to core0.
      bus.dREN = 2'b11; bus.daddr[0] = 32'h800; bus.daddr[1] = 32'h900;
      sample("s6c0"); next_cycle();
      sample("s6c1"); `CHK("s6c1.ren", bus.ramREN, 1'b1) `CHK("s6c1.addr", bus.ramaddr, 32'h900)
      do_reset("s6rst");
      sample("s6c2"); next_cycle();
      bus.ramstate = cpu_types_pkg::ACCESS;
      sample("s6c3"); `CHK("s6c3.addr", bus.ramaddr, 32'h800) `CHK("s6c3.dwait", bus.dwait, 2'b10) next_cycle();
      clear_req(); sample("s6c4"); next_cycle();

      // Random traffic against the model.
      repeat (400) begin
         for (int c = 0; c < CPUS; c++) begin
            if ($urandom_range(3) == 0) begin
               bus.iREN[c] = 1'($urandom_range(1));
               bus.dREN[c] = 1'($urandom_range(1));
               bus.dWEN[c] = 1'($urandom_range(1));
            end
            bus.iaddr[c]  = $urandom;
            bus.daddr[c]  = $urandom;
            bus.dstore[c] = $urandom;
         end
         bus.ramload = $urandom;
         r = int'($urandom_range(9));
         if (r < 4)      bus.ramstate = cpu_types_pkg::ACCESS;
         else if (r < 7) bus.ramstate = cpu_types_pkg::FREE;
         else if (r < 9) bus.ramstate = cpu_types_pkg::BUSY;
         else            bus.ramstate = cpu_types_pkg::ERROR;
         sample("rnd");
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
